// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, 4-beat burst memory port.
// One line read or write-back becomes one burst; the cache sees a single-cycle resp_o.
module cacheline_adaptor #(
    parameter int s_offset  = 5,
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    localparam int CW = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [CW-1:0] LAST = CW'(num_beats - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                            state;
    logic [CW-1:0]                     cnt;
    logic [num_beats-1:0][s_burst-1:0] buf_q;
    logic [31:0]                       addr_q;
    logic [31:0]                       addr_aligned;
    logic [CW-1:0]                     cnt_nxt;

    assign addr_aligned = {address_i[31:s_offset], {s_offset{1'b0}}};
    assign cnt_nxt      = (cnt == LAST) ? '0 : cnt + 1'b1;

    assign line_o    = buf_q;
    assign address_o = addr_q;
    // write_o is high exactly while in WRITE, so it doubles as the beat-valid gate
    assign burst_o   = write_o ? buf_q[cnt] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            read_o  <= 1'b0;
            write_o <= 1'b0;
            resp_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // write-back of the dirty victim must precede the refill
                    if (write_i) begin
                        buf_q   <= line_i;
                        addr_q  <= addr_aligned;
                        write_o <= 1'b1;
                        state   <= WRITE;
                    end else if (read_i) begin
                        addr_q <= addr_aligned;
                        read_o <= 1'b1;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        buf_q[cnt] <= burst_i;
                        cnt        <= cnt_nxt;
                        if (cnt == LAST) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt_nxt;
                        if (cnt == LAST) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
